// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared types and constants for the 8N1 UART receiver with FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 43;  // 5 MHz / 115200 baud

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte_fifo
// Brief    : First-word-fall-through byte FIFO; occupancy held in a count reg.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [UART_DATA_BITS-1:0]     data_i,
    input  logic                          pop_i,
    output logic [UART_DATA_BITS-1:0]     data_o,
    output logic                          valid_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          drop_o
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [c_PTR_W-1:0]        wr_ptr_q;
    logic [c_PTR_W-1:0]        rd_ptr_q;
    logic [c_PTR_W:0]          count_q;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (count_q == c_FULL);
    assign w_empty   = (count_q == '0);
    assign w_do_pop  = pop_i & ~w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = push_i & (~w_full | w_do_pop);
    assign drop_o    = push_i & ~w_do_push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = ~w_empty;
    assign level_o = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_reader
// Brief    : 8N1 UART receiver feeding a FWFT byte FIFO, with sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_reader
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ser_rx_i,
    output logic [UART_DATA_BITS-1:0]     data_o,
    output logic                          data_valid_o,
    input  logic                          data_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clr_err_i,
    output logic                          busy_o
);

    localparam logic [15:0]        c_HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]        c_BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam int                 c_IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT  = c_IDX_W'(UART_DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_fall;

    uart_rx_state_e             state_q,   state_d;
    logic [15:0]                cnt_q,     cnt_d;
    logic [c_IDX_W-1:0]         bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q,   shift_d;
    logic                       frame_err_q, frame_err_d;
    logic                       overrun_q,   overrun_d;

    logic w_tick;
    logic w_push;
    logic w_ferr_set;
    logic w_drop;

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ser_rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign w_fall = prev_q & ~sync2_q;
    assign w_tick = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_fall) begin
                    state_d = START;
                    cnt_d   = c_HALF_LOAD;
                end
            end
            START: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!sync2_q) begin
                    state_d   = DATA;
                    cnt_d     = c_BIT_LOAD;
                    bit_idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = c_BIT_LOAD;
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + c_IDX_ONE;
                    end
                end
            end
            STOP: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d    = IDLE;
                    w_push     = sync2_q;
                    w_ferr_set = ~sync2_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error outranks a clear arriving in the same cycle.
        frame_err_d = w_ferr_set | (frame_err_q & ~clr_err_i);
        overrun_d   = w_drop     | (overrun_q   & ~clr_err_i);
    end

    uart_rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (shift_q),
        .pop_i   (data_ready_i),
        .data_o  (data_o),
        .valid_o (data_valid_o),
        .level_o (level_o),
        .drop_o  (w_drop)
    );

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo_reader
// Brief    : Directed bench with a queue-level reference model of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_reader;

    localparam int C   = 43;
    localparam int D   = 8;
    // Line falls after edge k: 2 sync edges + edge-detect edge, half bit, 9 bits.
    localparam int OFS = 3 + C / 2 + 9 * C;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       ser_rx   = 1'b1;
    logic       ready    = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [3:0] level;
    logic       ferr;
    logic       ovr;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_fifo_reader #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ser_rx_i     (ser_rx),
        .data_o       (data),
        .data_valid_o (valid),
        .data_ready_i (ready),
        .level_o      (level),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .clr_err_i    (clr),
        .busy_o       (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq [$];
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;
    int         ev_cyc  [$];
    logic [7:0] ev_byte [$];
    bit         ev_good [$];
    logic [7:0] pop_log [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: frames become push / framing-error events at a known edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            ev_cyc.delete();
            ev_byte.delete();
            ev_good.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin : upd
            bit set_f;
            bit set_o;
            set_f = 1'b0;
            set_o = 1'b0;
            if (ready && mq.size() > 0) void'(mq.pop_front());
            if (ev_cyc.size() > 0 && ev_cyc[0] == cyc + 1) begin
                if (ev_good[0]) begin
                    if (mq.size() < D) mq.push_back(ev_byte[0]);
                    else               set_o = 1'b1;
                end else begin
                    set_f = 1'b1;
                end
                void'(ev_cyc.pop_front());
                void'(ev_byte.pop_front());
                void'(ev_good.pop_front());
            end
            if (clr) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (set_f) m_ferr = 1'b1;
            if (set_o) m_ovr  = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && valid && ready) pop_log.push_back(data);
    end

    always @(negedge clk) begin
        chk("valid", valid, mq.size() != 0);
        chk("level", level, mq.size());
        if (mq.size() > 0) chk("data", data, mq[0]);
        chk("frame_err", ferr, m_ferr);
        chk("overrun", ovr, m_ovr);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        ev_cyc.push_back(cyc + OFS);
        ev_byte.push_back(b);
        ev_good.push_back(stop_ok);
        ser_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            tick(C);
        end
        ser_rx = stop_ok;
        tick(C);
        ser_rx = 1'b1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    logic [7:0] exp3 [3];
    logic [7:0] bc3;
    int         k;

    initial begin
        exp3 = '{8'h00, 8'hFF, 8'hA5};
        bc3  = 8'hC3;

        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {ferr, ovr}, 2'b00);
        rst_n = 1'b1;
        tick(5);

        // Single byte, consumer stalled
        send(8'h55, 1'b1);
        tick(2);
        chk("single_valid", valid, 1);
        chk("single_data", data, 8'h55);
        chk("single_level", level, 1);
        chk("single_busy", busy, 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);

        // Back-to-back stream, consumer always ready
        pop_log.delete();
        ready = 1'b1;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'hA5, 1'b1);
        tick(5);
        ready = 1'b0;
        chk("b2b_count", pop_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (pop_log.size() > i) chk("b2b_byte", pop_log[i], exp3[i]);
        end
        chk("b2b_flags", {ferr, ovr}, 2'b00);

        // Glitch shorter than half a bit
        k = cyc;
        ser_rx = 1'b0;
        tick(5);
        chk("glitch_busy_hi", busy, 1);
        tick(5);
        ser_rx = 1'b1;
        tick(40);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_level", level, 0);
        chk("glitch_flags", {ferr, ovr}, 2'b00);

        // Framing error, clear, then a good frame
        send(8'h3C, 1'b0);
        tick(20);
        chk("ferr_set", ferr, 1);
        chk("ferr_level", level, 0);
        clr_pulse();
        chk("ferr_clr", ferr, 0);
        send(8'h3C, 1'b1);
        tick(2);
        chk("ferr_next_data", data, 8'h3C);
        chk("ferr_next_level", level, 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);

        // Overrun: nine bytes into eight entries
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1);
        tick(2);
        chk("ovr_level", level, 8);
        chk("ovr_flag", ovr, 1);
        chk("ovr_head", data, 8'h01);
        pop_log.delete();
        ready = 1'b1;
        tick(12);
        ready = 1'b0;
        chk("ovr_drain_count", pop_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (pop_log.size() > i) chk("ovr_drain_byte", pop_log[i], 8'(i + 1));
        end
        chk("ovr_drained", level, 0);
        clr_pulse();
        chk("ovr_clr", ovr, 0);

        // Reset during data bit 4 with a byte already queued
        send(8'h5A, 1'b1);
        tick(2);
        chk("pre_rst_level", level, 1);
        ser_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            ser_rx = bc3[i];
            tick(C);
        end
        ser_rx = bc3[4];
        tick(10);
        chk("mid_busy", busy, 1);
        rst_n  = 1'b0;
        ser_rx = 1'b1;
        tick(1);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        send(8'hC3, 1'b1);
        tick(2);
        chk("post_rst_data", data, 8'hC3);
        chk("post_rst_level", level, 1);
        chk("post_rst_flags", {ferr, ovr}, 2'b00);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
